// File: rtl/asy_fifo_n2w_if.sv
// Handshake/data bundle for the narrow-to-wide FIFO.
// The producer/consumer side uses "master"; the FIFO uses "slave".
interface asy_fifo_n2w_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                    wr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    rd;
    logic [2*DATA_WIDTH-1:0] r_data;
    logic                    full;
    logic                    empty;
    logic [ADDR_WIDTH:0]     count;

    modport master (
        output wr, w_data, rd,
        input  r_data, full, empty, count
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, full, empty, count
    );
endinterface

// File: rtl/asy_fifo_n2w.sv
// Narrow-write / wide-read FIFO: packs pairs of DATA_WIDTH words into one
// 2*DATA_WIDTH show-ahead word, older word in the low half.
module asy_fifo_n2w #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic           clk,
    input  logic           reset,
    asy_fifo_n2w_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH+1:0] CNT_DEPTH = (ADDR_WIDTH+2)'(DEPTH);
    localparam logic [ADDR_WIDTH+1:0] CNT_TWO   = (ADDR_WIDTH+2)'(2);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_hi;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [ADDR_WIDTH+1:0] count_ext;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance uses only registered flags, so a slot freed by a read in
    // this cycle is not reusable by a write in the same cycle.
    assign wr_acc = bus.wr & ~full_q;
    assign rd_acc = bus.rd & ~empty_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_ext = {1'b0, count_q};
        if (wr_acc) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            count_ext = count_ext + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(2);
            count_ext = count_ext - CNT_TWO;
        end
        count_d = count_ext[ADDR_WIDTH:0];
        full_d  = (count_ext == CNT_DEPTH);
        empty_d = (count_ext < CNT_TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is deliberately left out of reset; pointers alone define contents.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q] <= bus.w_data;
        end
    end

    assign rd_ptr_hi  = rd_ptr_q + 1'b1;
    assign bus.r_data = {mem_q[rd_ptr_hi], mem_q[rd_ptr_q]};
    assign bus.full   = full_q;
    assign bus.empty  = empty_q;
    assign bus.count  = count_q;
endmodule

// File: doc/asy_fifo_n2w.md
Name: asy_fifo_n2w

Overview:
Asymmetric narrow-to-wide FIFO with register-file storage and control. The write side pushes one DATA_WIDTH word per accepted write; the read side pops one 2*DATA_WIDTH word per accepted read, made of two consecutive narrow words. It is the counterpart of the team's wide-write/narrow-read FIFO and packs byte streams into 16-bit words for downstream consumers. Single clock domain.

Parameters:
DATA_WIDTH, 8, width of one narrow (write-side) word
ADDR_WIDTH, 3, narrow-word address width; depth = 2**ADDR_WIDTH narrow words; must be >= 1 so depth is even

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
wr  input  1  write request; accepted when full==0
w_data  input  DATA_WIDTH  narrow write data, sampled on an accepted write
rd  input  1  read request; accepted when empty==0
r_data  output  2*DATA_WIDTH  wide read data, show-ahead; {newer word, older word}
full  output  1  1 when all 2**ADDR_WIDTH narrow slots are occupied
empty  output  1  1 when fewer than 2 narrow words are stored (no complete wide word)
count  output  ADDR_WIDTH+1  number of narrow words stored, 0..2**ADDR_WIDTH

Behaviour:
- Reset is synchronous. While reset==1 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, full=0, empty=1. Storage is not cleared. reset takes priority over wr and rd in the same cycle.
- full, empty and count are registered and reflect state after the most recent edge. They are never combinational from wr or rd.
- Write acceptance: wr_acc = wr & ~full, evaluated on the current registered full. On wr_acc: mem[wr_ptr] <= w_data, wr_ptr <= wr_ptr+1 (mod depth).
- Read acceptance: rd_acc = rd & ~empty, evaluated on the current registered empty. On rd_acc: rd_ptr <= rd_ptr+2 (mod depth).
- rd_ptr is always even, because it starts at 0 and only advances by 2.
- r_data = {mem[rd_ptr+1], mem[rd_ptr]}, read combinationally from storage. The older word is in bits [DATA_WIDTH-1:0].
- r_data is valid whenever empty==0. Its value when empty==1 is don't-care.
- Rejected requests:
  - wr while full: ignored. No storage write, no pointer or count change.
  - rd while empty: ignored. Pointers and count are unchanged.
  - Neither case has any error output.
- count_next = count + wr_acc - 2*rd_acc. Compute at ADDR_WIDTH+2 bits internally; the result is always in range 0..depth.
- full_next = (count_next == depth). empty_next = (count_next < 2).
- Simultaneous wr and rd: each is qualified independently against the current flags. Required cases:
  - count==2, wr, rd: both accepted; count becomes 1, empty becomes 1.
  - full: rd accepted, wr rejected; count becomes depth-2. There is no write-through into a slot freed in the same cycle.
  - count==1: wr accepted, rd rejected; count becomes 2, empty becomes 0.
- Latency: a word written at edge N is visible in r_data from edge N onward, provided it completes a pair at rd_ptr.
- Odd residue: a single leftover narrow word (count==1) stays stored with empty==1 until a second word arrives. It is never emitted half-filled.
- Pointer wrap: both pointers wrap modulo 2**ADDR_WIDTH. Ordering is preserved across wrap.
- Reset mid-operation: all contents are logically discarded. The first write after reset goes to address 0.

Test Plan:
Use DATA_WIDTH=8, ADDR_WIDTH=3 (depth 8) for all scenarios.
1. Reset, then write 0xA1 -> count=1, empty=1. Then write 0xB2 -> count=2, empty=0, r_data=16'hB2A1.
2. From reset, write 0x01..0x08 on 8 consecutive cycles -> full=1, count=8. A 9th write of 0xFF is ignored. Reading 4 times returns 16'h0201, 16'h0403, 16'h0605, 16'h0807; after the 4th read empty=1, count=0, full=0.
3. Simultaneous events:
   - count=2 holding {0x22,0x11}: wr=1 with 0x33, rd=1 -> read returns 16'h2211, count=1, empty=1.
   - full (count=8): wr=1, rd=1 -> count=6, full=0, written data not stored.
4. count=1: rd=1 alone -> ignored, count stays 1. On empty FIFO (count=0): rd=1 -> no change, empty=1.
5. Wrap-around: stream 0x00..0x13 (20 words), reading whenever empty==0 with random wr/rd gaps -> reads are 16'h0100, 16'h0302, ..., 16'h1312 in order; full never overflows; final count=0.
6. Reset mid-operation: with count=5, assert reset for 1 cycle together with wr=1 -> count=0, empty=1, full=0, write ignored. Then write 0x5A, 0xA5 -> r_data=16'hA55A, from address 0.
